// File: rtl/alu_pkg.sv
// Shared constants, opcodes, FSM encodings and the single-cycle ALU function
// for the execute stage. Optional multiplier is enabled with ALU_MUL_EN.
package alu_pkg;

  localparam int DATA_W = 19;
  localparam int REG_AW = 5;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL = 4'd6;
  localparam logic [OP_W-1:0] OP_MUL = 4'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              sets_carry;
    logic              legal;
  } alu_out_t;

  // MUL is reported legal only when the iterative multiplier is built in;
  // its result comes from the multiplier, not from this function.
  function automatic alu_out_t alu_compute(input logic [OP_W-1:0]   op,
                                           input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b);
    alu_out_t        o;
    logic [DATA_W:0] wide;
    logic [4:0]      amt;
    o     = '0;
    o.legal = 1'b1;
    wide  = '0;
    amt   = b[4:0];
    case (op)
      OP_ADD: begin
        wide         = {1'b0, a} + {1'b0, b};
        o.result     = wide[DATA_W-1:0];
        o.carry      = wide[DATA_W];
        o.sets_carry = 1'b1;
      end
      OP_SUB: begin
        o.result     = a - b;
        o.carry      = (a < b);
        o.sets_carry = 1'b1;
      end
      OP_AND: o.result = a & b;
      OP_OR:  o.result = a | b;
      OP_XOR: o.result = a ^ b;
      OP_SLL: o.result = (amt >= 5'(DATA_W)) ? '0 : (a << amt);
      OP_SRL: o.result = (amt >= 5'(DATA_W)) ? '0 : (a >> amt);
`ifdef ALU_MUL_EN
      OP_MUL: o.legal = 1'b1;
`endif
      default: o.legal = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle; product is the
// low DATA_W bits and is valid while done is high. Only used with ALU_MUL_EN.
module alu_mul_iter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic [DATA_W-1:0] product,
  output logic              done
);

  logic [DATA_W-1:0] mcand_reg;
  logic [DATA_W-1:0] mplier_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] acc_next;
  logic [4:0]        count_reg;
  logic              busy_reg;

  // done is raised during the final step so the top can capture acc_next
  // on the same edge that retires the last multiplier bit.
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done     = busy_reg && (count_reg == 5'(DATA_W - 1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= multiplicand;
      mplier_reg <= multiplier;
      acc_reg    <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + 5'd1;
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops with registered write-back to the register
// file; define ALU_MUL_EN to add the iterative multiplier that stalls in_ready.
module alu_exec_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] aluresult,
  output logic              writeenable,
  output logic [REG_AW-1:0] wb_rd,
  output logic              carry,
  output logic              illegal_op
);

  logic [DATA_W-1:0] aluresult_reg, aluresult_next;
  logic [REG_AW-1:0] wb_rd_reg, wb_rd_next;
  logic              we_reg, we_next;
  logic              carry_reg, carry_next;
  logic              illegal_reg, illegal_next;
  logic              accept;
  logic              single_ok;
  alu_out_t          alu_o;

  assign alu_o  = alu_compute(op, operand_a, operand_b);
  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  state_t            state_reg, state_next;
  logic [REG_AW-1:0] mul_rd_reg;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign in_ready  = (state_reg == ST_IDLE);
  assign mul_start = accept && (op == OP_MUL);
  assign single_ok = accept && alu_o.legal && (op != OP_MUL);

  alu_mul_iter u_mul (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (mul_start),
    .multiplicand (operand_a),
    .multiplier   (operand_b),
    .product      (mul_product),
    .done         (mul_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      mul_rd_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (mul_start) mul_rd_reg <= rd_in;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (mul_start) state_next = ST_MUL;
      ST_MUL:  if (mul_done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end
`else
  assign in_ready  = 1'b1;
  assign single_ok = accept && alu_o.legal;
`endif

  // Register-file write port: outputs hold whenever no write is retired.
  always_comb begin
    aluresult_next = aluresult_reg;
    wb_rd_next     = wb_rd_reg;
    we_next        = 1'b0;
    carry_next     = carry_reg;
    illegal_next   = accept && !alu_o.legal;
    if (single_ok) begin
      aluresult_next = alu_o.result;
      wb_rd_next     = rd_in;
      we_next        = |rd_in;
      if (alu_o.sets_carry) carry_next = alu_o.carry;
    end
`ifdef ALU_MUL_EN
    if (mul_done) begin
      aluresult_next = mul_product;
      wb_rd_next     = mul_rd_reg;
      we_next        = |mul_rd_reg;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aluresult_reg <= '0;
      wb_rd_reg     <= '0;
      we_reg        <= 1'b0;
      carry_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      aluresult_reg <= aluresult_next;
      wb_rd_reg     <= wb_rd_next;
      we_reg        <= we_next;
      carry_reg     <= carry_next;
      illegal_reg   <= illegal_next;
    end
  end

  assign aluresult   = aluresult_reg;
  assign wb_rd       = wb_rd_reg;
  assign writeenable = we_reg;
  assign carry       = carry_reg;
  assign illegal_op  = illegal_reg;

endmodule
